// File: rtl/display7_bcd2_if.sv
// Sample-in / segments-out bundle between the ADC quantiser and the dual 7-segment display.
// master drives the sample and watches the segments; slave is the converter.
interface display7_bcd2_if;
  logic [3:0]  ADC;
  logic [13:0] D7;

  modport master (output ADC, input D7);
  modport slave  (input ADC, output D7);
endinterface

// File: rtl/display7_bcd2.sv
// Registered 4-bit sample to two-digit decimal 7-segment converter (00..15).
// D7[13:7] holds the tens digit and D7[6:0] the units digit, segments ordered a..g from MSB.
module display7_bcd2 #(
  parameter bit SEG_ACTIVE_LOW     = 1'b0,
  parameter bit BLANK_LEADING_ZERO = 1'b0
) (
  input  logic            CLK,
  input  logic            RST,
  display7_bcd2_if.slave  bus
);

  localparam logic [13:0] BLANK_PATTERN = SEG_ACTIVE_LOW ? 14'h3FFF : 14'h0000;

  logic [13:0] d7_q;
  logic [13:0] d7_d;
  logic        tens;
  logic [3:0]  units;
  logic [6:0]  tens_seg;
  logic [6:0]  units_seg;
  logic [13:0] encoded;

  // Input is at most 15, so one compare and one conditional subtract yields both digits.
  always_comb begin
    tens  = (bus.ADC >= 4'd10);
    units = bus.ADC - (tens ? 4'd10 : 4'd0);
  end

  always_comb begin
    units_seg = 7'b0000000;
    case (units)
      4'd0:    units_seg = 7'b1111110;
      4'd1:    units_seg = 7'b0110000;
      4'd2:    units_seg = 7'b1101101;
      4'd3:    units_seg = 7'b1111001;
      4'd4:    units_seg = 7'b0110011;
      4'd5:    units_seg = 7'b1011011;
      4'd6:    units_seg = 7'b1011111;
      4'd7:    units_seg = 7'b1110000;
      4'd8:    units_seg = 7'b1111111;
      4'd9:    units_seg = 7'b1111011;
      default: units_seg = 7'b0000000;
    endcase
  end

  always_comb begin
    tens_seg = 7'b0000000;
    if (tens) begin
      tens_seg = 7'b0110000;
    end else if (!BLANK_LEADING_ZERO) begin
      tens_seg = 7'b1111110;
    end
  end

  // Polarity is applied last so the blank reset pattern follows the same rule.
  always_comb begin
    encoded = {tens_seg, units_seg};
    d7_d    = SEG_ACTIVE_LOW ? ~encoded : encoded;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      d7_q <= BLANK_PATTERN;
    end else begin
      d7_q <= d7_d;
    end
  end

  assign bus.D7 = d7_q;

endmodule

// File: tb/tb_display7_bcd2.sv
// Three converter variants (default, leading-zero blanking, active-low) driven from one sample
// stream; a scoreboard queue holds the expected patterns for each edge.
module tb_display7_bcd2;

  logic clk;
  logic rst;
  logic [3:0] adc;

  display7_bcd2_if if_def ();
  display7_bcd2_if if_blk ();
  display7_bcd2_if if_al  ();

  assign if_def.ADC = adc;
  assign if_blk.ADC = adc;
  assign if_al.ADC  = adc;

  display7_bcd2 #(.SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING_ZERO(1'b0)) dut_def (.CLK(clk), .RST(rst), .bus(if_def));
  display7_bcd2 #(.SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING_ZERO(1'b1)) dut_blk (.CLK(clk), .RST(rst), .bus(if_blk));
  display7_bcd2 #(.SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b0)) dut_al  (.CLK(clk), .RST(rst), .bus(if_al));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          adc;
    logic [13:0] e_def;
    logic [13:0] e_blk;
    logic [13:0] e_al;
  } exp_t;

  exp_t sb[$];
  int checks;
  int errors;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'h7E; 1: s = 7'h30; 2: s = 7'h6D; 3: s = 7'h79; 4: s = 7'h33;
      5: s = 7'h5B; 6: s = 7'h5F; 7: s = 7'h70; 8: s = 7'h7F; 9: s = 7'h7B;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [13:0] model(input int v, input bit blank, input bit al);
    int t;
    int u;
    logic [6:0] ts;
    logic [13:0] r;
    t  = v / 10;
    u  = v % 10;
    ts = (blank && t == 0) ? 7'h00 : seg_of(t);
    r  = {ts, seg_of(u)};
    return al ? ~r : r;
  endfunction

  // Apply a sample half a cycle before the edge and queue what that edge must produce.
  task automatic drive(input int v);
    exp_t e;
    @(negedge clk);
    adc     = v[3:0];
    e.adc   = v;
    e.e_def = model(v, 1'b0, 1'b0);
    e.e_blk = model(v, 1'b1, 1'b0);
    e.e_al  = model(v, 1'b0, 1'b1);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    adc = 4'd7;
    #1;
    checks += 3;
    if (if_def.D7 !== 14'h0000) begin errors++; $display("FAIL reset_def got=%h want=%h", if_def.D7, 14'h0000); end
    if (if_blk.D7 !== 14'h0000) begin errors++; $display("FAIL reset_blk got=%h want=%h", if_blk.D7, 14'h0000); end
    if (if_al.D7  !== 14'h3FFF) begin errors++; $display("FAIL reset_al got=%h want=%h", if_al.D7, 14'h3FFF); end
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if (if_def.D7 !== 14'h0000) begin errors++; $display("FAIL reset_hold_def got=%h want=%h", if_def.D7, 14'h0000); end
    if (if_al.D7  !== 14'h3FFF) begin errors++; $display("FAIL reset_hold_al got=%h want=%h", if_al.D7, 14'h3FFF); end
    $display("reset: def=%h blk=%h al=%h", if_def.D7, if_blk.D7, if_al.D7);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_release();
    exp_t e;
    drive(0);
    e = sb.pop_front();
    checks += 4;
    if (if_def.D7 !== 14'h3F7E) begin errors++; $display("FAIL release_def got=%h want=%h", if_def.D7, 14'h3F7E); end
    if (if_def.D7 !== e.e_def)  begin errors++; $display("FAIL release_sb_def got=%h want=%h", if_def.D7, e.e_def); end
    if (if_blk.D7 !== e.e_blk)  begin errors++; $display("FAIL release_blk got=%h want=%h", if_blk.D7, e.e_blk); end
    if (if_al.D7  !== 14'h0081) begin errors++; $display("FAIL release_al got=%h want=%h", if_al.D7, 14'h0081); end
    $display("release adc=0 def=%h blk=%h al=%h", if_def.D7, if_blk.D7, if_al.D7);
  endtask

  task automatic test_rollover();
    exp_t e;
    logic [13:0] want [2];
    want[0] = 14'h3F7B;
    want[1] = 14'h187E;
    for (int i = 0; i < 2; i++) begin
      drive(9 + i);
      e = sb.pop_front();
      checks += 3;
      if (if_def.D7 !== want[i]) begin errors++; $display("FAIL rollover_def adc=%0d got=%h want=%h", e.adc, if_def.D7, want[i]); end
      if (if_blk.D7 !== e.e_blk) begin errors++; $display("FAIL rollover_blk adc=%0d got=%h want=%h", e.adc, if_blk.D7, e.e_blk); end
      if (if_al.D7  !== e.e_al)  begin errors++; $display("FAIL rollover_al adc=%0d got=%h want=%h", e.adc, if_al.D7, e.e_al); end
      $display("rollover adc=%0d def=%h", e.adc, if_def.D7);
    end
  endtask

  task automatic test_sweep();
    exp_t e;
    for (int v = 0; v < 16; v++) begin
      drive(v);
      e = sb.pop_front();
      checks += 3;
      if (if_def.D7 !== e.e_def) begin errors++; $display("FAIL sweep_def adc=%0d got=%h want=%h", e.adc, if_def.D7, e.e_def); end
      if (if_blk.D7 !== e.e_blk) begin errors++; $display("FAIL sweep_blk adc=%0d got=%h want=%h", e.adc, if_blk.D7, e.e_blk); end
      if (if_al.D7  !== e.e_al)  begin errors++; $display("FAIL sweep_al adc=%0d got=%h want=%h", e.adc, if_al.D7, e.e_al); end
      $display("sweep adc=%0d def=%h blk=%h al=%h", e.adc, if_def.D7, if_blk.D7, if_al.D7);
    end
  endtask

  task automatic test_spot();
    exp_t e;
    int vals [3];
    logic [13:0] want_def [3];
    logic [13:0] want_blk [3];
    vals[0] = 15; want_def[0] = 14'h185B; want_blk[0] = 14'h185B;
    vals[1] = 5;  want_def[1] = 14'h3F5B; want_blk[1] = 14'h005B;
    vals[2] = 12; want_def[2] = 14'h186D; want_blk[2] = 14'h186D;
    for (int i = 0; i < 3; i++) begin
      drive(vals[i]);
      e = sb.pop_front();
      checks += 2;
      if (if_def.D7 !== want_def[i]) begin errors++; $display("FAIL spot_def adc=%0d got=%h want=%h", e.adc, if_def.D7, want_def[i]); end
      if (if_blk.D7 !== want_blk[i]) begin errors++; $display("FAIL spot_blk adc=%0d got=%h want=%h", e.adc, if_blk.D7, want_blk[i]); end
      $display("spot adc=%0d def=%h blk=%h", e.adc, if_def.D7, if_blk.D7);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 24; i++) begin
      drive(int'($urandom_range(0, 15)));
      e = sb.pop_front();
      checks += 3;
      if (if_def.D7 !== e.e_def) begin errors++; $display("FAIL b2b_def adc=%0d got=%h want=%h", e.adc, if_def.D7, e.e_def); end
      if (if_blk.D7 !== e.e_blk) begin errors++; $display("FAIL b2b_blk adc=%0d got=%h want=%h", e.adc, if_blk.D7, e.e_blk); end
      if (if_al.D7  !== e.e_al)  begin errors++; $display("FAIL b2b_al adc=%0d got=%h want=%h", e.adc, if_al.D7, e.e_al); end
      $display("b2b adc=%0d def=%h blk=%h al=%h", e.adc, if_def.D7, if_blk.D7, if_al.D7);
    end
  endtask

  // Reset is raised between edges; the outputs must blank before the next rising edge.
  task automatic test_async_reset();
    exp_t e;
    drive(8);
    e = sb.pop_front();
    checks += 1;
    if (if_def.D7 !== e.e_def) begin errors++; $display("FAIL pre_async_def got=%h want=%h", if_def.D7, e.e_def); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks += 3;
    if (if_def.D7 !== 14'h0000) begin errors++; $display("FAIL async_def got=%h want=%h", if_def.D7, 14'h0000); end
    if (if_blk.D7 !== 14'h0000) begin errors++; $display("FAIL async_blk got=%h want=%h", if_blk.D7, 14'h0000); end
    if (if_al.D7  !== 14'h3FFF) begin errors++; $display("FAIL async_al got=%h want=%h", if_al.D7, 14'h3FFF); end
    $display("async reset: def=%h blk=%h al=%h", if_def.D7, if_blk.D7, if_al.D7);
    @(negedge clk);
    rst = 1'b0;
    drive(3);
    e = sb.pop_front();
    checks += 2;
    if (if_def.D7 !== e.e_def) begin errors++; $display("FAIL post_async_def got=%h want=%h", if_def.D7, e.e_def); end
    if (if_al.D7  !== e.e_al)  begin errors++; $display("FAIL post_async_al got=%h want=%h", if_al.D7, e.e_al); end
    $display("post reset adc=3 def=%h al=%h", if_def.D7, if_al.D7);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    adc    = 4'd0;
    test_reset();
    test_release();
    test_rollover();
    test_sweep();
    test_spot();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
